rr_process_scheduler: RTL and testbench

- Round-robin process scheduler for the kernel/user environment logic.
- Keeps a ready mask of user processes and runs the time-slice (quantum) counter.
- On quantum expiry, selects the next ready PID after the current one and raises a kernel trap.
- The trap is held until the kernel acknowledges it with a kernel swap, at which point the selected PID becomes current. PID 0 is the BIOS/kernel and is never scheduled.

---
 rtl/rr_process_scheduler.sv | 143 ++++++++++++++
 tb/tb_rr_process_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_process_scheduler.sv
// Round-robin scheduler for user processes. It keeps the ready bitmap and the
// quantum counter, and on expiry it picks the next ready PID and raises a trap to the kernel.
module rr_process_scheduler #(
  parameter int unsigned QUANTUM = 32,
  parameter int unsigned NPROC   = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rr_start,
  input  logic             block,
  input  logic             kernel_swap,
  input  logic             set_pid,
  input  logic [4:0]       pid_in,
  input  logic             proc_add,
  input  logic             proc_del,
  input  logic [4:0]       proc_id,
  output logic [4:0]       cur_pid,
  output logic [4:0]       next_pid,
  output logic             next_valid,
  output logic             trap,
  output logic [NPROC-1:0] ready_mask,
  output logic             busy
);

  // state | meaning
  // IDLE  | no slice running, waiting for rr_start
  // RUN   | slice running, quantum counter advancing
  // HOLD  | slice frozen by block, counter held
  // PICK  | one cycle: search ready mask for the next PID
  // TRAP  | kernel entry requested, waiting for kernel_swap
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_PICK, S_TRAP} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);
  localparam logic [5:0]       NP6      = 6'(NPROC);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       cur_q;
  logic [4:0]       next_q;
  logic             next_valid_q;
  logic [NPROC-1:0] ready_q;
  logic [NPROC-1:0] ready_d;

  logic [5:0]       cur_inc;
  logic [4:0]       start;
  logic [4:0]       pick_pid;
  logic             pick_found;

  always_comb begin
    ready_d = ready_q;
    for (int i = 1; i < NPROC; i++) begin
      if (proc_id == 5'(i)) begin
        if (proc_del)      ready_d[i] = 1'b0;
        else if (proc_add) ready_d[i] = 1'b1;
      end
    end
    ready_d[0] = 1'b0;
  end

  // The search begins at (cur+1) mod NPROC with 0 mapped to 1. Pass one covers
  // slots from start upward, pass two covers slots below start, so cur comes last.
  always_comb begin
    cur_inc = {1'b0, cur_q} + 6'd1;
    start   = 5'(cur_inc % NP6);
    if (start == 5'd0) start = 5'd1;
    pick_pid   = 5'd0;
    pick_found = 1'b0;
    for (int i = 1; i < NPROC; i++) begin
      if (!pick_found && ready_q[i] && (5'(i) >= start)) begin
        pick_found = 1'b1;
        pick_pid   = 5'(i);
      end
    end
    for (int i = 1; i < NPROC; i++) begin
      if (!pick_found && ready_q[i]) begin
        pick_found = 1'b1;
        pick_pid   = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cur_q        <= 5'd0;
      next_q       <= 5'd0;
      next_valid_q <= 1'b0;
      ready_q      <= '0;
    end else begin
      ready_q <= ready_d;
      if (kernel_swap) begin
        if (state_q == S_TRAP) cur_q <= next_q;
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else if (set_pid) begin
        cur_q <= pid_in;
        cnt_q <= '0;
        if (state_q == S_PICK || state_q == S_TRAP) begin
          state_q      <= S_IDLE;
          next_valid_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rr_start) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end
          end
          // Leaving HOLD counts as a run cycle, so each HOLD cycle costs exactly one.
          S_RUN, S_HOLD: begin
            if (block) begin
              state_q <= S_HOLD;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= S_PICK;
              cnt_q   <= '0;
            end else begin
              state_q <= S_RUN;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          S_PICK: begin
            next_q       <= pick_pid;
            next_valid_q <= pick_found;
            state_q      <= S_TRAP;
          end
          S_TRAP:  state_q <= S_TRAP;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cur_pid    = cur_q;
  assign next_pid   = next_q;
  assign next_valid = next_valid_q;
  assign trap       = (state_q == S_TRAP);
  assign busy       = (state_q == S_RUN) || (state_q == S_HOLD);
  assign ready_mask = ready_q;

endmodule

// File: tb/tb_rr_process_scheduler.sv
// Bench for rr_process_scheduler: directed slice scenarios with literal expectations,
// then random opcode traffic compared every cycle against a behavioural model.
module tb_rr_process_scheduler;
  localparam int Q  = 4;
  localparam int NP = 8;

  logic          clk, reset, rr_start, block, kernel_swap, set_pid, proc_add, proc_del;
  logic [4:0]    pid_in, proc_id, cur_pid, next_pid;
  logic          next_valid, trap, busy;
  logic [NP-1:0] ready_mask;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model of the scheduler in terms of slice progress rather than states
  int m_cur, m_next, m_elapsed;
  bit m_nvalid, m_active, m_pick_due, m_trap;
  bit m_rdy[NP];

  rr_process_scheduler #(.QUANTUM(Q), .NPROC(NP), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .rr_start(rr_start), .block(block),
    .kernel_swap(kernel_swap), .set_pid(set_pid), .pid_in(pid_in),
    .proc_add(proc_add), .proc_del(proc_del), .proc_id(proc_id),
    .cur_pid(cur_pid), .next_pid(next_pid), .next_valid(next_valid),
    .trap(trap), .ready_mask(ready_mask), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input int cur, output bit found);
    int s;
    int p;
    s = (cur + 1) % NP;
    if (s == 0) s = 1;
    found = 0;
    for (int k = 0; k < NP - 1; k++) begin
      p = ((s - 1 + k) % (NP - 1)) + 1;
      if (m_rdy[p]) begin
        found = 1;
        return p;
      end
    end
    return 0;
  endfunction

  function automatic int mask_int();
    int m;
    m = 0;
    for (int i = 0; i < NP; i++) if (m_rdy[i]) m += (1 << i);
    return m;
  endfunction

  always @(posedge clk) begin
    bit pf;
    int pp;
    bit nr[NP];
    pp = model_pick(m_cur, pf);
    if (reset) begin
      m_cur = 0; m_next = 0; m_elapsed = 0;
      m_nvalid = 0; m_active = 0; m_pick_due = 0; m_trap = 0;
      for (int i = 0; i < NP; i++) m_rdy[i] = 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        nr[i] = m_rdy[i];
        if (i != 0 && int'(proc_id) == i) begin
          if (proc_del)      nr[i] = 0;
          else if (proc_add) nr[i] = 1;
        end
      end
      if (kernel_swap) begin
        if (m_trap) m_cur = m_next;
        m_active = 0; m_pick_due = 0; m_trap = 0; m_elapsed = 0;
      end else if (set_pid) begin
        m_cur = int'(pid_in);
        m_elapsed = 0;
        if (m_pick_due || m_trap) begin
          m_pick_due = 0; m_trap = 0; m_nvalid = 0;
        end
      end else if (m_trap) begin
        m_trap = 1;
      end else if (m_pick_due) begin
        m_next = pp; m_nvalid = pf; m_pick_due = 0; m_trap = 1;
      end else if (m_active) begin
        if (!block) begin
          if (m_elapsed == Q - 1) begin
            m_active = 0; m_elapsed = 0; m_pick_due = 1;
          end else begin
            m_elapsed++;
          end
        end
      end else if (rr_start) begin
        m_active = 1; m_elapsed = 0;
      end
      for (int i = 0; i < NP; i++) m_rdy[i] = nr[i];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cur_pid", int'(cur_pid), m_cur);
      chk("next_pid", int'(next_pid), m_next);
      chk("next_valid", int'(next_valid), int'(m_nvalid));
      chk("trap", int'(trap), int'(m_trap));
      chk("busy", int'(busy), int'(m_active));
      chk("ready_mask", int'(ready_mask), mask_int());
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_add(input int id);
    proc_add = 1; proc_id = 5'(id); step(); proc_add = 0;
  endtask

  task automatic pulse_del(input int id);
    proc_del = 1; proc_id = 5'(id); step(); proc_del = 0;
  endtask

  task automatic pulse_setpid(input int id);
    set_pid = 1; pid_in = 5'(id); step(); set_pid = 0;
  endtask

  task automatic swap();
    kernel_swap = 1; step(); kernel_swap = 0;
  endtask

  task automatic run_slice(input string name, input int exp_lat);
    int lat;
    rr_start = 1; step(); rr_start = 0;
    lat = 0;
    while (!trap && lat < 40) begin
      step();
      lat++;
    end
    chk(name, lat, exp_lat);
  endtask

  initial begin
    int lat;
    reset = 1; rr_start = 0; block = 0; kernel_swap = 0; set_pid = 0;
    proc_add = 0; proc_del = 0; pid_in = 0; proc_id = 0;
    step(); step();
    chk_en = 1;
    chk("rst_cur", int'(cur_pid), 0);
    chk("rst_trap", int'(trap), 0);
    chk("rst_mask", int'(ready_mask), 0);
    reset = 0;

    pulse_add(2); pulse_add(5);
    pulse_setpid(2);
    chk("setpid_cur", int'(cur_pid), 2);
    run_slice("lat_first", 5);
    chk("first_next", int'(next_pid), 5);
    chk("first_valid", int'(next_valid), 1);
    swap();
    chk("swap_cur", int'(cur_pid), 5);
    chk("swap_trap", int'(trap), 0);
    chk("swap_busy", int'(busy), 0);

    run_slice("lat_wrap", 5);
    chk("wrap_next", int'(next_pid), 2);
    swap();
    pulse_del(2);
    pulse_setpid(5);
    run_slice("lat_self", 5);
    chk("self_next", int'(next_pid), 5);
    chk("self_valid", int'(next_valid), 1);
    swap();
    pulse_del(5);
    run_slice("lat_empty", 5);
    chk("empty_next", int'(next_pid), 0);
    chk("empty_valid", int'(next_valid), 0);
    swap();
    chk("empty_cur", int'(cur_pid), 0);

    pulse_add(3);
    rr_start = 1; step(); rr_start = 0;
    step();
    block = 1; step();
    chk("busy_in_hold", int'(busy), 1);
    step(); step();
    block = 0;
    lat = 4;
    while (!trap && lat < 40) begin
      step();
      lat++;
    end
    chk("lat_hold", lat, 8);
    chk("hold_next", int'(next_pid), 3);
    swap();

    rr_start = 1; step(); rr_start = 0;
    step();
    swap();
    chk("abort_trap", int'(trap), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cur", int'(cur_pid), 3);
    step(); step(); step(); step(); step();
    chk("abort_no_trap", int'(trap), 0);
    run_slice("lat_after_abort", 5);
    chk("after_abort_next", int'(next_pid), 3);
    swap();

    proc_add = 1; proc_del = 1; proc_id = 5'd3; step(); proc_add = 0; proc_del = 0;
    chk("mask_del_wins", int'(ready_mask), 0);
    pulse_add(4);
    pulse_add(0);
    pulse_add(9);
    chk("mask_ignore_bad_id", int'(ready_mask), 16);

    run_slice("lat_pre_setpid", 5);
    chk("pre_setpid_next", int'(next_pid), 4);
    pulse_setpid(7);
    chk("setpid_trap_drop", int'(trap), 0);
    chk("setpid_trap_cur", int'(cur_pid), 7);
    chk("setpid_trap_valid", int'(next_valid), 0);

    rr_start = 1; step(); rr_start = 0;
    step();
    chk("run_busy", int'(busy), 1);
    reset = 1; step(); reset = 0;
    chk("rst2_cur", int'(cur_pid), 0);
    chk("rst2_next", int'(next_pid), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_mask", int'(ready_mask), 0);

    pulse_add(1); pulse_add(6);
    pulse_setpid(9);
    run_slice("lat_big_pid", 5);
    chk("big_pid_next", int'(next_pid), 6);
    swap();
    chk("big_pid_cur", int'(cur_pid), 6);

    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(199) == 0);
      kernel_swap = ($urandom_range(24) == 0);
      set_pid     = ($urandom_range(29) == 0);
      rr_start    = ($urandom_range(3) == 0);
      block       = ($urandom_range(5) == 0);
      proc_add    = ($urandom_range(2) == 0);
      proc_del    = ($urandom_range(4) == 0);
      proc_id     = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(8));
      pid_in      = ($urandom_range(5) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      step();
    end
    reset = 0; kernel_swap = 0; set_pid = 0; rr_start = 0; block = 0;
    proc_add = 0; proc_del = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
